// File: rtl/dds_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_pkg : shared widths, quadrant/tag types and sine-table helpers       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dds_pkg;

  localparam int PHASE_W = 28;
  localparam int IDX_W   = 10;
  localparam int LUT_AW  = 8;
  localparam int LUT_DW  = 9;
  localparam int DAC_W   = 10;
  localparam logic [DAC_W-1:0] SINE_MID = 10'd512;

  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_FALL = 2'd2,
    Q_NEG_RISE = 2'd3
  } quadrant_e;

  // Side information travelling down the sine pipeline next to the ROM read.
  typedef struct packed {
    logic      valid;
    logic      sq;
    quadrant_e quad;
  } tag_t;

  function automatic logic [LUT_AW-1:0] fold_addr(input quadrant_e q,
                                                  input logic [LUT_AW-1:0] a);
    return (q == Q_FALL || q == Q_NEG_RISE) ? ~a : a;
  endfunction

  function automatic logic [DAC_W-1:0] apply_sign(input quadrant_e q,
                                                  input logic [LUT_DW-1:0] mag);
    if (q == Q_RISE || q == Q_FALL) begin
      return SINE_MID + DAC_W'(mag);
    end
    return (SINE_MID - DAC_W'(1)) - DAC_W'(mag);
  endfunction

  // Elaboration-time table entry: round(511*sin(2*pi*(i+0.5)/1024)) via Taylor series.
  function automatic logic [LUT_DW-1:0] sine_entry(input int i);
    real x;
    real term;
    real acc;
    x    = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / 1024.0;
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return LUT_DW'($rtoi(511.0 * acc + 0.5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_rom_q.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sine_rom_q : quarter-wave sine table, synchronous read, 1-cycle latency  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sine_rom_q
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_DW-1:0] data
);

  logic [LUT_DW-1:0] table_w [2**LUT_AW];
  logic [LUT_DW-1:0] data_q;
  logic [LUT_DW-1:0] data_d;

  for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
    localparam logic [LUT_DW-1:0] C_ENTRY = sine_entry(gi);
    assign table_w[gi] = C_ENTRY;
  end

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = table_w[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/dds_phase_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_phase_accum : DDS phase accumulator with glitch-filtered tuning word |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dds_phase_accum
  import dds_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic [PHASE_W-1:0] M,
  input  logic               EN,
  output logic [DAC_W-1:0]   SINE,
  output logic               SQ,
  output logic               WRAP,
  output logic [PHASE_W-1:0] PHASE
);

  logic [PHASE_W-1:0] m_s1_q, m_s1_d;
  logic [PHASE_W-1:0] m_s2_q, m_s2_d;
  logic [PHASE_W-1:0] m_s3_q, m_s3_d;
  logic [PHASE_W-1:0] p_q, p_d;
  logic [PHASE_W-1:0] a_q, a_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W:0]   sum_w;

  logic [IDX_W-1:0]   idx_w;
  quadrant_e          quad_w;
  tag_t               tag1_q, tag1_d;
  tag_t               tag2_q, tag2_d;
  logic [LUT_AW-1:0]  addr1_q, addr1_d;
  logic [LUT_DW-1:0]  rom_data_w;
  logic [DAC_W-1:0]   sine_q, sine_d;
  logic               sq_q, sq_d;

  assign sum_w = {1'b0, phase_q} + {1'b0, a_q};

  // The synchronizer and pending word keep running while EN is low.
  always_comb begin
    m_s1_d  = M;
    m_s2_d  = m_s1_q;
    m_s3_d  = m_s2_q;
    p_d     = (m_s2_q == m_s3_q) ? m_s2_q : p_q;
    phase_d = phase_q;
    a_d     = a_q;
    wrap_d  = 1'b0;
    if (EN) begin
      phase_d = sum_w[PHASE_W-1:0];
      wrap_d  = sum_w[PHASE_W];
      if (sum_w[PHASE_W] || (a_q == '0)) begin
        a_d = p_q;
      end
    end
  end

  assign idx_w  = phase_q[PHASE_W-1 -: IDX_W];
  assign quad_w = quadrant_e'(idx_w[IDX_W-1 -: 2]);

  // Samples taken while the active word is zero are not emitted, so SINE
  // holds its last value (midscale after reset) until the accumulator runs.
  always_comb begin
    tag1_d  = tag1_q;
    addr1_d = addr1_q;
    tag2_d  = tag2_q;
    sine_d  = sine_q;
    sq_d    = sq_q;
    if (EN) begin
      tag1_d  = '{valid: (a_q != '0), sq: phase_q[PHASE_W-1], quad: quad_w};
      addr1_d = fold_addr(quad_w, idx_w[LUT_AW-1:0]);
      tag2_d  = tag1_q;
      sq_d    = tag2_q.sq;
      if (tag2_q.valid) begin
        sine_d = apply_sign(tag2_q.quad, rom_data_w);
      end
    end
  end

  sine_rom_q u_rom (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .en    (EN),
    .addr  (addr1_q),
    .data  (rom_data_w)
  );

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      m_s1_q  <= '0;
      m_s2_q  <= '0;
      m_s3_q  <= '0;
      p_q     <= '0;
      a_q     <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      tag1_q  <= '0;
      addr1_q <= '0;
      tag2_q  <= '0;
      sine_q  <= SINE_MID;
      sq_q    <= 1'b0;
    end else begin
      m_s1_q  <= m_s1_d;
      m_s2_q  <= m_s2_d;
      m_s3_q  <= m_s3_d;
      p_q     <= p_d;
      a_q     <= a_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      tag1_q  <= tag1_d;
      addr1_q <= addr1_d;
      tag2_q  <= tag2_d;
      sine_q  <= sine_d;
      sq_q    <= sq_d;
    end
  end

  assign PHASE = phase_q;
  assign WRAP  = wrap_q;
  assign SINE  = sine_q;
  assign SQ    = sq_q;

endmodule
`default_nettype wire
